// File: rtl/mesh_terminal_agent.sv
// mesh_terminal_agent
//
// Edge-terminal endpoint for the mesh router array.
//   * Driver side: host packets are buffered in a small first-word-fall-through
//     FIFO and offered to the mesh (pndng_i_in / data_out_i_in, consumed by popin).
//   * Receiver side: packets delivered by the mesh (pndng / data_out) are taken
//     with a single-cycle pop, captured, destination-checked and counted.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   push           in   host write strobe
//   push_data      in   host packet
//   full           out  FIFO full
//   overflow       out  sticky: a push was dropped because the FIFO was full
//   pndng_i_in     out  FIFO not empty, head offered to the mesh
//   data_out_i_in  out  FIFO head (combinational)
//   popin          in   mesh consumes the FIFO head
//   pndng          in   mesh has a packet for this terminal
//   data_out       in   mesh packet, valid while pndng=1
//   pop            out  one-cycle pulse taking the mesh packet
//   rcv_valid      out  one-cycle pulse, rcv_data/rcv_ok valid
//   rcv_data       out  captured packet
//   rcv_ok         out  destination check result
//   rcv_cnt        out  saturating received-packet count
//   err_cnt        out  saturating check-failure count
//
// Build option
//   MESH_TERM_CHECK_EN : when defined, the destination check and err_cnt are
//                        active. When undefined, rcv_ok is tied to 1 and
//                        err_cnt to 0.
//
// Receiver FSM
//   state | meaning
//   IDLE  | waiting for pndng
//   TAKE  | pop asserted, capture data_out and evaluate the check
//   GAP   | rcv_valid asserted; gives the mesh a cycle to update pndng

module mesh_terminal_agent #(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [3:0] ROW_ID     = 4'd0,
  parameter logic [3:0] COL_ID     = 4'd0,
  parameter logic [7:0] bdcst      = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] push_data,
  output logic               full,
  output logic               overflow,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               popin,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               rcv_valid,
  output logic [pckg_sz-1:0] rcv_data,
  output logic               rcv_ok,
  output logic [15:0]        rcv_cnt,
  output logic [15:0]        err_cnt
);

  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = $clog2(fifo_depth) + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(fifo_depth - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(fifo_depth);

  // ---------------------------------------------------------------- driver FIFO
  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full          = (count_q == DEPTH_C);
  assign pndng_i_in    = (count_q != '0);
  assign data_out_i_in = mem_q[rd_ptr_q];
  assign overflow      = overflow_q;

  // A pop frees the slot the simultaneous push writes into, so a full FIFO
  // still accepts a push when popin is high in the same cycle.
  assign do_pop  = popin && pndng_i_in;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
    if (push && !do_push)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {IDLE, TAKE, GAP} state_t;

  state_t             state_q, state_d;
  logic [pckg_sz-1:0] rcv_data_q;
  logic [15:0]        rcv_cnt_q;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    rcv_valid = 1'b0;
    case (state_q)
      IDLE: if (pndng) state_d = TAKE;
      TAKE: begin
        pop     = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        rcv_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rcv_data_q <= '0;
      rcv_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == TAKE) rcv_data_q <= data_out;
      if (rcv_valid && (rcv_cnt_q != 16'hFFFF)) rcv_cnt_q <= rcv_cnt_q + 16'd1;
    end
  end

  assign rcv_data = rcv_data_q;
  assign rcv_cnt  = rcv_cnt_q;

`ifdef MESH_TERM_CHECK_EN
  logic        rcv_ok_q;
  logic [15:0] err_cnt_q;
  logic        dst_ok;

  assign dst_ok = (data_out[pckg_sz-1 -: 8] == bdcst) ||
                  ((data_out[pckg_sz-9 -: 4] == ROW_ID) &&
                   (data_out[pckg_sz-13 -: 4] == COL_ID));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcv_ok_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (state_q == TAKE) rcv_ok_q <= dst_ok;
      if (rcv_valid && !rcv_ok_q && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign rcv_ok  = rcv_ok_q;
  assign err_cnt = err_cnt_q;
`else
  // Identity parameters are only consumed by the check; keep them referenced.
  logic unused_cfg;
  assign unused_cfg = ^{ROW_ID, COL_ID, bdcst};

  assign rcv_ok  = 1'b1;
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mesh_terminal_agent.sv
module tb_mesh_terminal_agent;

  localparam int PSZ = 40;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           push = 1'b0;
  logic [PSZ-1:0] push_data = '0;
  logic           full, overflow, pndng_i_in;
  logic [PSZ-1:0] data_out_i_in;
  logic           popin = 1'b0;
  logic           pndng = 1'b0;
  logic [PSZ-1:0] data_out = '0;
  logic           pop, rcv_valid, rcv_ok;
  logic [PSZ-1:0] rcv_data;
  logic [15:0]    rcv_cnt, err_cnt;

  mesh_terminal_agent #(
    .pckg_sz(PSZ), .fifo_depth(4), .ROW_ID(4'd2), .COL_ID(4'd0), .bdcst(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data),
    .full(full), .overflow(overflow), .pndng_i_in(pndng_i_in),
    .data_out_i_in(data_out_i_in), .popin(popin), .pndng(pndng),
    .data_out(data_out), .pop(pop), .rcv_valid(rcv_valid),
    .rcv_data(rcv_data), .rcv_ok(rcv_ok), .rcv_cnt(rcv_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

`ifdef MESH_TERM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int popq[$];
  logic [PSZ-1:0] fq[$];   // expected FIFO output order
  logic [PSZ:0]   rq[$];   // expected {rcv_ok, rcv_data}

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (reset) begin
      if (popin && pndng_i_in) begin
        if (fq.size() == 0) chk("fifo_unexpected_pop", 1, 0);
        else chk("fifo_head", data_out_i_in, fq.pop_front());
      end
      if (rcv_valid) begin
        if (rq.size() == 0) chk("rcv_unexpected", 1, 0);
        else begin
          logic [PSZ:0] e;
          e = rq.pop_front();
          chk("rcv_data", rcv_data, e[PSZ-1:0]);
          chk("rcv_ok", rcv_ok, e[PSZ]);
        end
      end
      if (pop) begin
        pop_cnt++;
        popq.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic fifo_pop();
    popin = 1'b1;
    @(posedge clk); #1;
    popin = 1'b0;
  endtask

  task automatic mesh_send(input logic [PSZ-1:0] pkt, input bit ok);
    int pc0;
    bit got;
    pc0 = pop_cnt;
    rq.push_back({(CHK ? ok : 1'b1), pkt});
    pndng = 1'b1;
    data_out = pkt;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      if (pop) got = 1'b1;
    end
    chk("pop_seen", got, 1);
    pndng = 1'b0;               // dropping pndng during TAKE must not cancel
    @(posedge clk); #1;
    data_out = '0;
    repeat (3) @(posedge clk);
    #1 chk("pop_once", pop_cnt - pc0, 1);
  endtask

  logic [PSZ-1:0] pv [5];

  initial begin
    pv[0] = 40'h01_1_1_000011;
    pv[1] = 40'h02_2_2_000022;
    pv[2] = 40'h03_3_3_000033;
    pv[3] = 40'h04_4_4_000044;
    pv[4] = 40'h05_5_5_000055;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_pndng_i_in", pndng_i_in, 0);
    chk("rst_data_out_i_in", data_out_i_in, 0);
    chk("rst_pop", pop, 0);
    chk("rst_rcv_valid", rcv_valid, 0);
    chk("rst_rcv_data", rcv_data, 0);
    chk("rst_rcv_ok", rcv_ok, CHK ? 0 : 1);
    chk("rst_rcv_cnt", rcv_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Single push, visible one edge later, then popped
    @(posedge clk); #1;
    push = 1'b1; push_data = 40'h00_2_0_800001;
    fq.push_back(40'h0020800001);
    @(posedge clk); #1;
    push = 1'b0;
    chk("wr_pndng_i_in", pndng_i_in, 1);
    chk("wr_data_out_i_in", data_out_i_in, 40'h0020800001);
    fifo_pop();
    chk("pop_empty", pndng_i_in, 0);

    // Fill past depth: 5th push dropped, overflow sticks
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_data = pv[i];
      if (i < 4) fq.push_back(pv[i]);
      @(posedge clk); #1;
      if (i == 3) begin
        chk("full_after_4", full, 1);
        chk("no_ovf_after_4", overflow, 0);
      end
    end
    push = 1'b0;
    chk("full_after_5", full, 1);
    chk("ovf_after_5", overflow, 1);
    for (int i = 0; i < 4; i++) fifo_pop();
    chk("drained_pndng", pndng_i_in, 0);
    chk("drained_full", full, 0);
    chk("ovf_sticky", overflow, 1);

    // Full FIFO: push and popin together
    do_reset();
    chk("ovf_cleared", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = pv[i];
      fq.push_back(pv[i]);
      @(posedge clk); #1;
    end
    push = 1'b1; push_data = 40'hAB_C_D_E0F001; popin = 1'b1;
    fq.push_back(40'hABCDE0F001);
    @(posedge clk); #1;
    push = 1'b0; popin = 1'b0;
    chk("simul_full", full, 1);
    chk("simul_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) fifo_pop();
    chk("simul_drained", pndng_i_in, 0);
    chk("fifo_q_empty", fq.size(), 0);

    // Receiver: matching, mismatching, broadcast
    mesh_send(40'h00_2_0_000055, 1'b1);
    chk("rcv_cnt_1", rcv_cnt, 1);
    chk("err_cnt_0", err_cnt, 0);
    mesh_send(40'h00_1_3_000066, 1'b0);
    chk("rcv_cnt_2", rcv_cnt, 2);
    chk("err_cnt_1", err_cnt, CHK ? 1 : 0);
    mesh_send(40'hFF_1_3_000066, 1'b1);
    chk("rcv_cnt_3", rcv_cnt, 3);
    chk("err_cnt_bdcst", err_cnt, CHK ? 1 : 0);

    // Continuous pndng: one pop every 3 cycles
    popq.delete();
    @(posedge clk); #1;
    pndng = 1'b1; data_out = 40'h00_2_0_0000AA;
    for (int i = 0; i < 3; i++) rq.push_back({1'b1, 40'h0020_0000AA});
    repeat (9) @(posedge clk);
    #1 pndng = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_pops", popq.size(), 3);
    if (popq.size() == 3) begin
      chk("pop_spacing_a", popq[1] - popq[0], 3);
      chk("pop_spacing_b", popq[2] - popq[1], 3);
    end
    chk("rcv_cnt_6", rcv_cnt, 6);
    data_out = '0;

    // Reset during TAKE
    begin
      bit got;
      pndng = 1'b1; data_out = 40'h00_2_0_0000BB;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(posedge clk); #1;
        if (pop) got = 1'b1;
      end
      chk("take_reached", got, 1);
      reset = 1'b0;
      #1;
      chk("rst_take_pop", pop, 0);
      chk("rst_take_rcv_valid", rcv_valid, 0);
      chk("rst_take_rcv_cnt", rcv_cnt, 0);
      chk("rst_take_err_cnt", err_cnt, 0);
      chk("rst_take_rcv_data", rcv_data, 0);
      pndng = 1'b0; data_out = '0;
      @(posedge clk); #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("idle_no_pop", pop, 0);
      pndng = 1'b1; data_out = 40'h00_2_0_0000CC;
      rq.push_back({1'b1, 40'h0020_0000CC});
      @(posedge clk); #1;
      chk("idle_to_take", pop, 1);
      pndng = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("rcv_cnt_after_rst", rcv_cnt, 1);
    end

    chk("rcv_q_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
